// File: rtl/pkt_receiver.sv
// Receive endpoint for length-prefixed packets: a header word, then len payload words.
// Payload is buffered and replayed with a last marker, and a status record is strobed per packet.
module pkt_receiver #(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              sts_valid,
    output logic [3:0]        sts_len,
    output logic [DATA_W-1:0] sts_csum,
    output logic [1:0]        sts_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PAYLOAD,
        ST_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          len_q, len_d;
    logic [3:0]          rem_q, rem_d;
    logic [DATA_W-1:0]   csum_q, csum_d;
    logic [1:0]          err_q, err_d;

    logic [DATA_W:0]     mem_q [FIFO_DEPTH];
    logic [AW-1:0]       wptr_q, rptr_q;
    logic [CW-1:0]       count_q;
    logic                fifo_full, fifo_empty;
    logic                wr_en, rd_en;
    logic                last_w;
    logic [DATA_W:0]     head;

    assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign last_w     = (rem_q == 4'd1);
    assign wr_en      = in_valid & in_ready & (state_q == ST_PAYLOAD);
    assign rd_en      = out_valid & out_ready;

    // Read side is decoupled from the FSM; empty forces zeros so nothing stale leaks out.
    assign head      = mem_q[rptr_q];
    assign out_valid = !fifo_empty;
    assign out_data  = out_valid ? head[DATA_W-1:0] : '0;
    assign out_last  = out_valid & head[DATA_W];

    assign sts_len  = len_q;
    assign sts_csum = csum_q;
    assign sts_err  = err_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wptr_q] <= {last_w, in_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (wr_en) wptr_q <= wptr_q + 1'b1;
            if (rd_en) rptr_q <= rptr_q + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            rem_q   <= '0;
            csum_q  <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            rem_q   <= rem_d;
            csum_q  <= csum_d;
            err_q   <= err_d;
        end
    end

    // in_ready is gated by rst_n so it reads 0 for the whole reset window.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        rem_d     = rem_q;
        csum_d    = csum_q;
        err_d     = err_q;
        in_ready  = 1'b0;
        sts_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = rst_n;
                if (in_valid & in_ready) begin
                    len_d  = in_data[3:0];
                    err_d  = {|in_data[DATA_W-1:4], (in_data[3:0] == 4'd0)};
                    csum_d = '0;
                    rem_d  = in_data[3:0];
                    state_d = (in_data[3:0] == 4'd0) ? ST_DONE : ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                in_ready = rst_n & !fifo_full;
                if (in_valid & in_ready) begin
                    csum_d = csum_q ^ in_data;
                    rem_d  = rem_q - 4'd1;
                    if (last_w) state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                sts_valid = 1'b1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_pkt_receiver.sv
// Directed bench for pkt_receiver: one task per scenario with inline expected values.
module tb_pkt_receiver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        out_last;
    logic        sts_valid;
    logic [3:0]  sts_len;
    logic [31:0] sts_csum;
    logic [1:0]  sts_err;

    int errs = 0;
    int checks = 0;
    int cyc = 0;

    logic [31:0] wq[$];
    logic        lq[$];
    logic [3:0]  slq[$];
    logic [31:0] scq[$];
    logic [1:0]  seq_q[$];

    pkt_receiver #(.DATA_W(32), .FIFO_DEPTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .sts_valid(sts_valid), .sts_len(sts_len), .sts_csum(sts_csum), .sts_err(sts_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Capture handshakes and status strobes mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            wq.push_back(out_data);
            lq.push_back(out_last);
        end
        if (sts_valid) begin
            slq.push_back(sts_len);
            scq.push_back(sts_csum);
            seq_q.push_back(sts_err);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    task automatic cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send(input logic [31:0] d, output int t);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (in_ready !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
        checks++;
        if (in_ready !== 1'b1) begin
            errs++;
            $display("FAIL send_timeout data=%h in_ready=%b required 1", d, in_ready);
        end
        @(posedge clk); #1;
        t = cyc;
        in_valid = 1'b0;
    endtask

    task automatic wait_words(input int n);
        int k;
        k = 0;
        while (wq.size() < n && k < 500) begin @(posedge clk); #1; k++; end
        checks++;
        if (wq.size() < n) begin
            errs++;
            $display("FAIL drain_timeout words=%0d required %0d", wq.size(), n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        out_ready = 1'b0;
        cycles(2);
        checks++;
        if ({in_ready, out_valid, out_last, sts_valid} !== 4'b0000) begin
            errs++;
            $display("FAIL reset_ctrl in_ready/out_valid/out_last/sts_valid=%b required 0000",
                     {in_ready, out_valid, out_last, sts_valid});
        end
        checks++;
        if ({out_data, sts_csum, sts_len, sts_err} !== 70'd0) begin
            errs++;
            $display("FAIL reset_data out_data=%h sts_csum=%h sts_len=%h sts_err=%b required 0",
                     out_data, sts_csum, sts_len, sts_err);
        end
        rst_n = 1'b1;
        cycles(1);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errs++;
            $display("FAIL reset_release in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_basic();
        int t, wb, sb;
        wb = wq.size(); sb = slq.size();
        out_ready = 1'b1;
        send(32'h0000_0003, t);
        checks++;
        if (out_valid !== 1'b0) begin
            errs++; $display("FAIL basic_hdr_not_written out_valid=%b required 0", out_valid);
        end
        send(32'h1111_1111, t);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h1111_1111 || out_last !== 1'b0) begin
            errs++;
            $display("FAIL basic_latency out_valid=%b out_data=%h out_last=%b required 1 11111111 0",
                     out_valid, out_data, out_last);
        end
        send(32'h2222_2222, t);
        send(32'h4444_4444, t);
        checks++;
        if (sts_valid !== 1'b1 || in_ready !== 1'b0 || sts_len !== 4'd3 ||
            sts_csum !== 32'h7777_7777 || sts_err !== 2'b00) begin
            errs++;
            $display("FAIL basic_status valid=%b in_ready=%b len=%0d csum=%h err=%b required 1 0 3 77777777 00",
                     sts_valid, in_ready, sts_len, sts_csum, sts_err);
        end
        cycles(1);
        checks++;
        if (sts_valid !== 1'b0 || in_ready !== 1'b1) begin
            errs++;
            $display("FAIL basic_status_one_cycle sts_valid=%b in_ready=%b required 0 1", sts_valid, in_ready);
        end
        cycles(3);
        checks++;
        if (wq.size() != wb + 3 || wq[wb] !== 32'h1111_1111 || wq[wb+1] !== 32'h2222_2222 ||
            wq[wb+2] !== 32'h4444_4444 || {lq[wb], lq[wb+1], lq[wb+2]} !== 3'b001) begin
            errs++;
            $display("FAIL basic_output words=%0d first=%h last=%h lasts=%b required 3 11111111 44444444 001",
                     wq.size() - wb, wq[wb], wq[wb+2], {lq[wb], lq[wb+1], lq[wb+2]});
        end
        checks++;
        if (slq.size() != sb + 1) begin
            errs++; $display("FAIL basic_sts_count pulses=%0d required 1", slq.size() - sb);
        end
    endtask

    task automatic test_zero_len();
        int t0, t1, wb, sb;
        wb = wq.size(); sb = slq.size();
        send(32'h0000_0000, t0);
        checks++;
        if (sts_valid !== 1'b1 || in_ready !== 1'b0 || sts_len !== 4'd0 ||
            sts_csum !== 32'd0 || sts_err !== 2'b01) begin
            errs++;
            $display("FAIL zero_status valid=%b in_ready=%b len=%0d csum=%h err=%b required 1 0 0 00000000 01",
                     sts_valid, in_ready, sts_len, sts_csum, sts_err);
        end
        send(32'h0000_0000, t1);
        checks++;
        if (t1 - t0 != 2) begin
            errs++; $display("FAIL zero_next_hdr_spacing cycles=%0d required 2", t1 - t0);
        end
        cycles(3);
        checks++;
        if (wq.size() != wb || out_valid !== 1'b0) begin
            errs++;
            $display("FAIL zero_no_write words=%0d out_valid=%b required 0 0", wq.size() - wb, out_valid);
        end
        checks++;
        if (slq.size() != sb + 2) begin
            errs++; $display("FAIL zero_sts_count pulses=%0d required 2", slq.size() - sb);
        end
    endtask

    task automatic test_err_hdr();
        int t, wb;
        wb = wq.size();
        out_ready = 1'b1;
        send(32'hABC0_0002, t);
        send(32'hDEAD_BEEF, t);
        send(32'h0000_0001, t);
        checks++;
        if (sts_valid !== 1'b1 || sts_len !== 4'd2 || sts_csum !== 32'hDEAD_BEEE || sts_err !== 2'b10) begin
            errs++;
            $display("FAIL errhdr_status valid=%b len=%0d csum=%h err=%b required 1 2 deadbeee 10",
                     sts_valid, sts_len, sts_csum, sts_err);
        end
        cycles(3);
        checks++;
        if (wq.size() != wb + 2 || wq[wb] !== 32'hDEAD_BEEF || wq[wb+1] !== 32'h0000_0001 ||
            {lq[wb], lq[wb+1]} !== 2'b01) begin
            errs++;
            $display("FAIL errhdr_output words=%0d w0=%h w1=%h lasts=%b required 2 deadbeef 00000001 01",
                     wq.size() - wb, wq[wb], wq[wb+1], {lq[wb], lq[wb+1]});
        end
    endtask

    task automatic test_full_wrap();
        int t, wb, sb, bad, nlast;
        logic [31:0] exp_w;
        logic        exp_l;
        wb = wq.size(); sb = slq.size();
        out_ready = 1'b0;
        send(32'h0000_000F, t);
        for (int i = 1; i <= 15; i++) send(32'h1000_0000 + i, t);
        send(32'h0000_000F, t);
        send(32'h2000_0001, t);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'h1000_0001) begin
            errs++;
            $display("FAIL full_stall in_ready=%b out_valid=%b out_data=%h required 0 1 10000001",
                     in_ready, out_valid, out_data);
        end
        cycles(3);
        checks++;
        if (in_ready !== 1'b0 || out_data !== 32'h1000_0001 || out_last !== 1'b0) begin
            errs++;
            $display("FAIL full_hold in_ready=%b out_data=%h out_last=%b required 0 10000001 0",
                     in_ready, out_data, out_last);
        end
        out_ready = 1'b1;
        for (int i = 2; i <= 15; i++) send(32'h2000_0000 + i, t);
        wait_words(wb + 30);
        bad = 0; nlast = 0;
        for (int k = 0; k < 30; k++) begin
            exp_w = (k < 15) ? (32'h1000_0001 + k) : (32'h2000_0001 + (k - 15));
            exp_l = (k == 14) || (k == 29);
            if (wq[wb+k] !== exp_w || lq[wb+k] !== exp_l) bad++;
            if (lq[wb+k] === 1'b1) nlast++;
        end
        checks++;
        if (bad != 0 || wq.size() != wb + 30) begin
            errs++;
            $display("FAIL full_order bad_words=%0d words=%0d required 0 30", bad, wq.size() - wb);
        end
        checks++;
        if (nlast != 2) begin
            errs++; $display("FAIL full_last_count lasts=%0d required 2", nlast);
        end
        checks++;
        if (slq.size() != sb + 2 || slq[sb] !== 4'hF || scq[sb] !== 32'h1000_0000 ||
            slq[sb+1] !== 4'hF || scq[sb+1] !== 32'h2000_0000 || seq_q[sb] !== 2'b00) begin
            errs++;
            $display("FAIL full_status pulses=%0d csum0=%h csum1=%h required 2 10000000 20000000",
                     slq.size() - sb, scq[sb], scq[sb+1]);
        end
    endtask

    task automatic test_reset_mid();
        int t, wb, sb;
        out_ready = 1'b0;
        sb = slq.size();
        send(32'h0000_0005, t);
        send(32'hA000_0001, t);
        in_valid = 1'b1;
        in_data  = 32'hA000_0002;
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, out_last, sts_valid} !== 4'b0000 ||
            {out_data, sts_csum, sts_len, sts_err} !== 70'd0) begin
            errs++;
            $display("FAIL midreset_outputs in_ready=%b out_valid=%b out_data=%h sts_len=%h sts_csum=%h required all 0",
                     in_ready, out_valid, out_data, sts_len, sts_csum);
        end
        in_valid = 1'b0;
        cycles(2);
        rst_n = 1'b1;
        cycles(2);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || slq.size() != sb) begin
            errs++;
            $display("FAIL midreset_discard in_ready=%b out_valid=%b pulses=%0d required 1 0 0",
                     in_ready, out_valid, slq.size() - sb);
        end
        out_ready = 1'b1;
        wb = wq.size();
        send(32'h0000_0001, t);
        send(32'hCAFE_F00D, t);
        checks++;
        if (sts_valid !== 1'b1 || sts_len !== 4'd1 || sts_csum !== 32'hCAFE_F00D || sts_err !== 2'b00) begin
            errs++;
            $display("FAIL midreset_recover_status valid=%b len=%0d csum=%h err=%b required 1 1 cafef00d 00",
                     sts_valid, sts_len, sts_csum, sts_err);
        end
        cycles(3);
        checks++;
        if (wq.size() != wb + 1 || wq[wb] !== 32'hCAFE_F00D || lq[wb] !== 1'b1 || slq.size() != sb + 1) begin
            errs++;
            $display("FAIL midreset_recover_output words=%0d w0=%h last=%b pulses=%0d required 1 cafef00d 1 1",
                     wq.size() - wb, wq[wb], lq[wb], slq.size() - sb);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_len();
        test_err_hdr();
        test_full_wrap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
